// File: rtl/uart_pkg.sv
// uart_pkg: constants and state encoding shared by the UART blocks.
// Both uart_tx and uart_rx take their frame shape from here.
package uart_pkg;

    localparam int   DATA_BITS = 8;
    localparam logic LINE_IDLE = 1'b1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } uart_state_e;

    function automatic int half_bit(input int cpb);
        return cpb / 2;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// sync_ff: multi-flop synchronizer for an asynchronous input.
// Flops reset to RESET_VAL so a held line reads idle after reset.
module sync_ff #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the raw input through the flop chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with a one-byte holding register.
// Start is qualified at mid-bit; bytes are dropped with a pulse when full.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int         HALF      = half_bit(CLKS_PER_BIT);
    localparam logic [7:0] LAST_CNT  = 8'(CLKS_PER_BIT - 1);
    localparam logic [7:0] HALF_CNT  = 8'((HALF > 0) ? HALF - 1 : 0);
    localparam logic [1:0] FILL_DONE = 2'(SYNC_STAGES);
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

    logic                 rx_s;
    uart_state_e          state_q;
    logic [7:0]           cnt_q;
    logic [2:0]           bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 frame_err_q;
    logic                 overrun_q;
    logic                 armed_q;
    logic [1:0]           fill_q;
    logic                 bit_tick;
    logic                 start_seen;

    sync_ff #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (LINE_IDLE)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx),
        .q_o (rx_s)
    );

    // Bit-period strobe and qualified falling edge of the line.
    always_comb begin
        bit_tick   = (cnt_q == LAST_CNT);
        start_seen = armed_q && (rx_s != LINE_IDLE);
    end

    // Frame FSM, bit timing and holding register.
    // armed_q waits for a real idle level after reset so a line
    // caught low mid-frame is not mistaken for a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            armed_q     <= 1'b0;
            fill_q      <= '0;
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;

            if (fill_q != FILL_DONE) begin
                fill_q <= fill_q + 2'd1;
            end else if (rx_s == LINE_IDLE) begin
                armed_q <= 1'b1;
            end

            if (valid_q && ready) begin
                valid_q <= 1'b0;
            end

            unique case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    bit_q <= '0;
                    if (start_seen) begin
                        state_q <= (HALF == 0) ? DATA : START;
                    end
                end
                START: begin
                    if (cnt_q == HALF_CNT) begin
                        cnt_q   <= '0;
                        state_q <= (rx_s == LINE_IDLE) ? IDLE : DATA;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        cnt_q          <= '0;
                        shift_q[bit_q] <= rx_s;
                        bit_q          <= bit_q + 3'd1;
                        if (bit_q == LAST_BIT) begin
                            state_q <= STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        cnt_q <= '0;
                        if (rx_s == LINE_IDLE) begin
                            state_q <= IDLE;
                            if (!valid_q || ready) begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= WAIT_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                WAIT_IDLE: begin
                    if (rx_s == LINE_IDLE) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule
